// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode defines: reset PC, NOP word, opcode/funct codes.
// Also the FIFO entry bundle and small PC helpers.
package fetch_unit_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: W-bit, DEPTH-entry FIFO with flush.
// Ports: push/din, pop/dout (head), flush, full, empty, count.
module fetch_fifo #(
  parameter int             W       = 64,
  parameter int             DEPTH   = 2,
  parameter int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int             CW      = $clog2(DEPTH + 1),
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP  = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests, in-order responses, redirect drop.
// Ports: imem_req/addr/ready/rvalid/rdata, stallD, redirectE/PcE, validD/instrD/pcD.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        redirectE,
  input  logic [31:0] redirectPcE,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          CW1     = CW + 1;
  localparam logic [CW:0] CREDITS = CW1'(DEPTH);
  localparam int          EW      = $bits(fetch_entry_t);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] occ;
  logic [CW-1:0] out_dec;
  logic [CW:0]   in_use;
  logic          accept;
  logic          resp;
  logic          dropping;
  logic          keep;
  logic          pop;
  logic          empty;
  logic          full;
  fetch_entry_t  head;
  fetch_entry_t  entry;

  assign target   = word_align(redirectPcE);
  assign in_use   = {1'b0, outstanding} + {1'b0, occ};

  // Credits cover both in-flight requests and buffered words.
  assign imem_req  = !rst && !redirectE && (in_use < CREDITS);
  assign imem_addr = fetch_pc;

  assign accept   = imem_req && imem_ready;
  assign resp     = imem_rvalid && (outstanding != '0);
  assign dropping = resp && (drop != '0);
  assign keep     = resp && !dropping && !redirectE;
  assign pop      = validD && !stallD && !redirectE;
  assign out_dec  = outstanding - CW'(resp);

  assign entry.pc    = resp_pc;
  assign entry.instr = imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_dec + CW'(accept);
      if (redirectE) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= out_dec;
      end else begin
        if (accept) begin
          fetch_pc <= pc_next(fetch_pc);
        end
        unique case (1'b1)
          keep:     resp_pc <= pc_next(resp_pc);
          dropping: drop    <= drop - 1'b1;
          default:  ;
        endcase
      end
    end
  end

  fetch_fifo #(
    .W       (EW),
    .DEPTH   (DEPTH),
    .CW      (CW),
    .RST_VAL ({RESET_PC, NOP})
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep && !full),
    .din   (entry),
    .pop   (pop),
    .flush (redirectE),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign validD = !empty;
  assign instrD = head.instr;
  assign pcD    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model,
// expected {pc, instr} queue, and a monitor comparing every pop.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stallD = 1'b0;
  logic        redirectE = 1'b0;
  logic [31:0] redirectPcE = 32'h0;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stallD      (stallD),
    .redirectE   (redirectE),
    .redirectPcE (redirectPcE),
    .validD      (validD),
    .instrD      (instrD),
    .pcD         (pcD)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] memq[$];
  logic [31:0] acc_log[$];
  logic        mem_hold = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pop_cnt = 0;
  int          acc_n;

  function automatic logic [31:0] mw(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return a ^ 32'h5A00_0013;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    logic [31:0] a;
    exp_t e;
    a = start;
    for (int i = 0; i < n; i++) begin
      e.pc = a;
      e.instr = mw(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int k;
    k = 0;
    while (pop_cnt < target && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (pop_cnt < target) begin
      n_errors++;
      $display("FAIL pop_timeout: got %0d pops expected %0d", pop_cnt, target);
    end
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k;
    k = 0;
    while (acc_log.size() < target && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (acc_log.size() < target) begin
      n_errors++;
      $display("FAIL acc_timeout: got %0d requests expected %0d",
               acc_log.size(), target);
    end
  endtask

  task automatic drain();
    imem_ready = 1'b0;
    stallD = 1'b0;
    repeat (6) step();
    exp_q.delete();
  endtask

  // Memory: record accepted requests before the edge, answer in order
  // one cycle later unless held.
  always @(negedge clk) begin
    if (imem_req && imem_ready) begin
      memq.push_back(imem_addr);
      acc_log.push_back(imem_addr);
    end
  end

  always @(posedge clk) begin
    #2;
    if (!mem_hold && memq.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mw(memq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Monitor: every decode hand-off is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && validD && !stallD && !redirectE) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got pc %h expected none", pcD);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", pcD, e.pc);
        chk("pop_instr", instrD, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_ready = 1'b1;
    push_run(32'h0, 12);

    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", validD, 0);
    chk("rst_instr", instrD, 32'h0);
    chk("rst_pc", pcD, 32'h0);

    step();
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    wait_pops(3, 40);
    chk("acc0", acc_at(0), 32'h0);
    chk("acc1", acc_at(1), 32'h4);
    chk("acc2", acc_at(2), 32'h8);

    stallD = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", imem_req, 0);
      chk("stall_valid", validD, 1);
      chk("stall_pc", pcD, 32'hC);
      chk("stall_instr", instrD, mw(32'hC));
      step();
    end
    stallD = 1'b0;
    @(negedge clk);
    chk("rel_valid0", validD, 1);
    chk("rel_pc0", pcD, 32'hC);
    step();
    @(negedge clk);
    chk("rel_valid1", validD, 1);
    chk("rel_pc1", pcD, 32'h10);
    chk("rel_req", imem_req, 1);
    step();

    drain();
    mem_hold = 1'b1;
    imem_ready = 1'b1;
    step();
    step();
    redirectE = 1'b1;
    redirectPcE = 32'h0000_0103;
    acc_n = acc_log.size();
    push_run(32'h100, 8);
    @(negedge clk);
    chk("redir_req", imem_req, 0);
    step();
    redirectE = 1'b0;
    mem_hold = 1'b0;
    wait_acc(acc_n + 1, 20);
    chk("redir_addr", acc_at(acc_n), 32'h100);
    wait_pops(pop_cnt + 3, 40);

    drain();
    mem_hold = 1'b1;
    imem_ready = 1'b1;
    step();
    step();
    redirectE = 1'b1;
    redirectPcE = 32'h0000_0200;
    stallD = 1'b1;
    mem_hold = 1'b0;
    acc_n = acc_log.size();
    push_run(32'h200, 8);
    @(negedge clk);
    chk("redir2_req", imem_req, 0);
    step();
    redirectE = 1'b0;
    stallD = 1'b0;
    wait_acc(acc_n + 1, 20);
    chk("redir2_addr", acc_at(acc_n), 32'h200);
    wait_pops(pop_cnt + 3, 40);

    drain();
    imem_ready = 1'b1;
    redirectE = 1'b1;
    redirectPcE = 32'hFFFF_FFFC;
    acc_n = acc_log.size();
    push_run(32'hFFFF_FFFC, 8);
    step();
    redirectE = 1'b0;
    wait_acc(acc_n + 2, 20);
    chk("wrap_addr0", acc_at(acc_n), 32'hFFFF_FFFC);
    chk("wrap_addr1", acc_at(acc_n + 1), 32'h0);
    wait_pops(pop_cnt + 3, 40);

    drain();
    mem_hold = 1'b1;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_req", imem_req, 0);
    chk("rst2_valid", validD, 0);
    chk("rst2_pc", pcD, 32'h0);
    step();
    rst = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    chk("rst2_first_req", imem_req, 1);
    chk("rst2_first_addr", imem_addr, 32'h0);
    chk("stray_valid0", validD, 0);
    step();
    @(negedge clk);
    chk("stray_valid1", validD, 0);
    acc_n = acc_log.size();
    push_run(32'h0, 8);
    step();
    imem_ready = 1'b1;
    wait_acc(acc_n + 1, 20);
    chk("rst2_acc", acc_at(acc_n), 32'h0);
    wait_pops(pop_cnt + 2, 40);

    drain();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
